// File: rtl/seven_segment_capture_if.sv
// Seven-segment display bus as seen by the capture block.
// master drives the active-low bus, slave returns decoded frames.
interface seven_segment_capture_if;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        bad_pattern;
  logic        multi_anode;

  modport master (
    output segment,
    output anode,
    input  value,
    input  dp,
    input  frame_valid,
    input  bad_pattern,
    input  multi_anode
  );

  modport slave (
    input  segment,
    input  anode,
    output value,
    output dp,
    output frame_valid,
    output bad_pattern,
    output multi_anode
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Reads back a multiplexed 4-digit seven-segment bus into hex frames.
// Define SEVEN_SEGMENT_CAPTURE_SYNC_EN to add a 2-FF input synchroniser.
module seven_segment_capture #(
  parameter int SETTLE_CYCLES = 16
) (
  input logic                    clk,
  input logic                    reset,
  seven_segment_capture_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SC_W = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE_W = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_e;

  logic [11:0] s;

`ifdef SEVEN_SEGMENT_CAPTURE_SYNC_EN
  logic [11:0] sync1_q;
  logic [11:0] sync2_q;

  // Idle bus value so reset never looks like a lit digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 12'hFFF;
      sync2_q <= 12'hFFF;
    end else begin
      sync1_q <= {bus.anode, bus.segment};
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = {bus.anode, bus.segment};
`endif

  logic       one_low;
  logic       all_high;
  logic       multi;
  logic [1:0] idx;

  always_comb begin
    one_low = 1'b0;
    idx     = 2'd0;
    case (s[11:8])
      4'b1110: begin one_low = 1'b1; idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; idx = 2'd3; end
      default: begin one_low = 1'b0; idx = 2'd0; end
    endcase
  end

  assign all_high = (s[11:8] == 4'hF);
  assign multi    = !one_low && !all_high;

  logic       glyph_ok;
  logic [3:0] nib;

  always_comb begin
    glyph_ok = 1'b1;
    nib      = 4'h0;
    case (s[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  count_inc;
  logic [11:0]    lat_q, lat_d;
  logic           load;
  logic           settle_done;

  assign count_inc = count_q + ONE_W;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lat_d       = lat_q;
    load        = 1'b0;
    settle_done = 1'b0;
    if (multi) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (one_low) load = 1'b1;
        end
        SETTLE: begin
          if (s == lat_q) begin
            count_d = count_inc;
            if (count_inc >= SC_W) begin
              settle_done = 1'b1;
              state_d     = CAPTURED;
            end
          end else if (one_low) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        CAPTURED: begin
          if (s != lat_q) begin
            if (one_low) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              count_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
      // A single-sample settle captures on the very first sample.
      if (load) begin
        lat_d   = s;
        count_d = ONE_W;
        if (SC_W == ONE_W) begin
          settle_done = 1'b1;
          state_d     = CAPTURED;
        end else begin
          state_d = SETTLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      lat_q   <= 12'hFFF;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lat_q   <= lat_d;
    end
  end

  logic        cap;
  logic        bad_d, bad_q;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  sdp_q, sdp_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  dp_q, dp_d;
  logic        fv_d, fv_q;

  assign cap   = settle_done && glyph_ok;
  assign bad_d = settle_done && !glyph_ok;

  always_comb begin
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    mask_d   = mask_q;
    value_d  = value_q;
    dp_d     = dp_q;
    fv_d     = 1'b0;
    if (mask_q == 4'hF) begin
      value_d = shadow_q;
      dp_d    = sdp_q;
      fv_d    = 1'b1;
      mask_d  = 4'h0;
    end
    // Same-cycle capture lands in the freshly cleared mask.
    if (cap) begin
      shadow_d[{idx, 2'b00} +: 4] = nib;
      sdp_d[idx]                  = ~s[7];
      mask_d[idx]                 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      sdp_q    <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      fv_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      fv_q     <= fv_d;
      bad_q    <= bad_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.dp          = dp_q;
  assign bus.frame_valid = fv_q;
  assign bus.bad_pattern = bad_q;
  assign bus.multi_anode = multi && !reset;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with SETTLE_CYCLES=4.
// Pulse outputs are tallied on the falling edge.
module tb_seven_segment_capture;

`ifdef SEVEN_SEGMENT_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fv_cnt = 0;
  int   fv_cyc = 0;
  int   bad_cnt = 0;
  int   multi_cnt = 0;
  int   f0, b0, m0, t0;

  seven_segment_capture_if bif();

  seven_segment_capture #(
    .SETTLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bif.frame_valid) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end
    if (bif.bad_pattern) bad_cnt = bad_cnt + 1;
    if (bif.multi_anode) multi_cnt = multi_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an,
                      input logic [7:0] sg,
                      input int n);
    repeat (n) begin
      bif.anode   = an;
      bif.segment = sg;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic blank(input int n);
    hold(4'hF, 8'hFF, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bif.anode   = 4'hF;
    bif.segment = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(bif.value), 32'h0);
    chk("rst_dp", 32'(bif.dp), 32'h0);
    chk("rst_fv", 32'(bif.frame_valid), 32'h0);
    chk("rst_bad", 32'(bif.bad_pattern), 32'h0);
    chk("rst_multi", 32'(bif.multi_anode), 32'h0);
    reset = 1'b0;
    blank(2);

    // 1: basic frame 4321, dp on digit 2
    f0 = fv_cnt; b0 = bad_cnt; m0 = multi_cnt;
    t0 = cyc;
    hold(4'hE, 8'hF9, 8);
    hold(4'hD, 8'hA4, 8);
    hold(4'hB, 8'h30, 8);
    hold(4'h7, 8'h99, 8);
    blank(4);
    chk("t1_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t1_fv_cycle", 32'(fv_cyc - t0), 32'(29 + LAT));
    chk("t1_value", 32'(bif.value), 32'h4321);
    chk("t1_dp", 32'(bif.dp), 32'h4);
    chk("t1_bad", 32'(bad_cnt - b0), 32'd0);
    chk("t1_multi", 32'(multi_cnt - m0), 32'd0);

    // 2: short glyph on digit 0 must not capture
    f0 = fv_cnt;
    hold(4'hE, 8'hC0, 3);
    blank(2);
    hold(4'hD, 8'h90, 8);
    hold(4'hB, 8'h80, 8);
    hold(4'h7, 8'hF8, 8);
    blank(3);
    chk("t2_no_frame", 32'(fv_cnt - f0), 32'd0);
    chk("t2_value_held", 32'(bif.value), 32'h4321);
    hold(4'hE, 8'h82, 8);
    blank(3);
    chk("t2_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t2_value", 32'(bif.value), 32'h7896);
    chk("t2_dp", 32'(bif.dp), 32'h0);

    // 3: blank glyph on digit 1 is a bad pattern
    f0 = fv_cnt; b0 = bad_cnt;
    hold(4'hD, 8'hFF, 8);
    blank(2);
    chk("t3_bad_count", 32'(bad_cnt - b0), 32'd1);
    hold(4'hE, 8'hF9, 8);
    hold(4'hB, 8'hA4, 8);
    hold(4'h7, 8'hB0, 8);
    blank(3);
    chk("t3_no_frame", 32'(fv_cnt - f0), 32'd0);
    hold(4'hD, 8'h88, 8);
    blank(3);
    chk("t3_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t3_value", 32'(bif.value), 32'h32A1);
    chk("t3_bad_total", 32'(bad_cnt - b0), 32'd1);

    // 4: multi-anode glitch restarts settling
    f0 = fv_cnt; m0 = multi_cnt;
    hold(4'hE, 8'h8E, 2);
    hold(4'hC, 8'h8E, 1);
    hold(4'hE, 8'h8E, 3);
    blank(2);
    chk("t4_multi_count", 32'(multi_cnt - m0), 32'd1);
    hold(4'hD, 8'h83, 8);
    hold(4'hB, 8'hC6, 8);
    hold(4'h7, 8'hA1, 8);
    blank(3);
    chk("t4_no_frame", 32'(fv_cnt - f0), 32'd0);
    hold(4'hE, 8'hC0, 8);
    blank(3);
    chk("t4_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t4_value", 32'(bif.value), 32'hDCB0);

    // 5: reset discards a partial frame
    hold(4'hE, 8'h92, 8);
    hold(4'hD, 8'h92, 8);
    hold(4'hB, 8'h92, 8);
    reset = 1'b1;
    blank(2);
    reset = 1'b0;
    chk("t5_rst_value", 32'(bif.value), 32'h0);
    f0 = fv_cnt;
    hold(4'h7, 8'hC6, 8);
    hold(4'hB, 8'hA1, 8);
    hold(4'hD, 8'h86, 8);
    hold(4'hE, 8'h8E, 8);
    blank(3);
    chk("t5_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t5_value", 32'(bif.value), 32'hCDEF);
    chk("t5_dp", 32'(bif.dp), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
